// File: rtl/ff_wr_arbiter_if.sv
// Requester-side bundle for ff_wr_arbiter: requests and data in, grant/storage view out.
// The lock vector exists only when FF_ARB_LOCK_EN is defined.
interface ff_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] wdata;
`ifdef FF_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;
`endif
  logic [NREQ-1:0]    gnt;
  logic               enb;
  logic [DW-1:0]      d;
  logic [DW-1:0]      q;
  logic               busy;

  modport master (
    output req,
    output wdata,
`ifdef FF_ARB_LOCK_EN
    output lock,
`endif
    input  gnt,
    input  enb,
    input  d,
    input  q,
    input  busy
  );

  modport slave (
    input  req,
    input  wdata,
`ifdef FF_ARB_LOCK_EN
    input  lock,
`endif
    output gnt,
    output enb,
    output d,
    output q,
    output busy
  );
endinterface

// File: rtl/ff_wr_arbiter.sv
// Round-robin write arbiter feeding one shared enable-gated register (q).
// Define FF_ARB_LOCK_EN to add per-requester grant locking (lock port, LOCKED state).
module ff_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic           cclk,
  input  logic           rst,
  ff_wr_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

`ifdef FF_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1} state_t;
`endif

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [DW-1:0]     d_reg, d_next;
  logic [DW-1:0]     q_reg;
  logic [PW-1:0]     ptr_reg, ptr_next;
`ifdef FF_ARB_LOCK_EN
  logic [PW-1:0]     gidx_reg, gidx_next;
  logic              lock_hold;
`endif

  logic [DW-1:0]     wdata_arr [NREQ];
  logic [PW-1:0]     cand [NREQ];
  logic [NREQ-1:0]   req_rot;
  logic              found;
  logic [PW-1:0]     win;

  // cand[k] is the k-th requester in search order starting at ptr.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign wdata_arr[gi] = bus.wdata[gi*DW +: DW];
    assign cand[gi]      = (int'(ptr_reg) + gi >= NREQ) ? PW'(int'(ptr_reg) + gi - NREQ)
                                                        : PW'(int'(ptr_reg) + gi);
    assign req_rot[gi]   = bus.req[cand[gi]];
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        win   = cand[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    d_next     = d_reg;
    ptr_next   = ptr_reg;
`ifdef FF_ARB_LOCK_EN
    gidx_next  = gidx_reg;
    lock_hold  = (state_reg != IDLE) && bus.req[gidx_reg] && bus.lock[gidx_reg];
    // Locked owner keeps gnt and ptr; only its data is refreshed.
    if (lock_hold) begin
      state_next = LOCKED;
      d_next     = wdata_arr[gidx_reg];
    end else
`endif
    if (found) begin
      state_next = GRANT;
      gnt_next   = {{(NREQ-1){1'b0}}, 1'b1} << win;
      d_next     = wdata_arr[win];
      ptr_next   = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
`ifdef FF_ARB_LOCK_EN
      gidx_next  = win;
`endif
    end else begin
      state_next = IDLE;
      gnt_next   = '0;
    end
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      d_reg     <= '0;
      ptr_reg   <= '0;
`ifdef FF_ARB_LOCK_EN
      gidx_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      d_reg     <= d_next;
      ptr_reg   <= ptr_next;
`ifdef FF_ARB_LOCK_EN
      gidx_reg  <= gidx_next;
`endif
    end
  end

  // Shared storage: enable is high exactly when a grant is outstanding.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (state_reg != IDLE) begin
      q_reg <= d_reg;
    end
  end

  assign bus.gnt = gnt_reg;
  assign bus.enb = (state_reg != IDLE);
  assign bus.d   = d_reg;
  assign bus.q   = q_reg;
`ifdef FF_ARB_LOCK_EN
  assign bus.busy = (state_reg == LOCKED);
`else
  assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_ff_wr_arbiter.sv
// Scoreboard bench for ff_wr_arbiter: expectations queued per driven cycle, checked after the edge.
module tb_ff_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  always #5 cclk = ~cclk;

  ff_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();
  ff_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (.cclk(cclk), .rst(rst), .bus(bus));

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic            enb;
    logic [DW-1:0]   d;
    logic [DW-1:0]   q;
    logic            busy;
    string           name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_q = '0;
  logic [DW-1:0] m_d = '0;
  logic          m_enb = 1'b0;

  task automatic set_wd(input int i, input logic [DW-1:0] v);
    bus.wdata[i*DW +: DW] = v;
  endtask

  task automatic set_lock(input logic [NREQ-1:0] lk);
`ifdef FF_ARB_LOCK_EN
    bus.lock = lk;
`else
    if (lk != '0) $display("note: lock ignored in this build");
`endif
  endtask

  // Drive one cycle of req, queue the expected post-edge outputs, then pop and compare.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] eg,
                      input logic eb, input string nm);
    exp_t e;
    exp_t o;
    int w;
    bus.req = r;
    w = 0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) w = i;
    e.q    = m_enb ? m_d : m_q;
    e.gnt  = eg;
    e.enb  = |eg;
    e.d    = (eg == '0) ? m_d : bus.wdata[w*DW +: DW];
    e.busy = eb;
    e.name = nm;
    sb.push_back(e);
    m_q = e.q; m_d = e.d; m_enb = e.enb;
    @(posedge cclk);
    #1;
    o = sb.pop_front();
    checks++;
    if (bus.gnt !== o.gnt) begin errors++; $display("FAIL %s gnt: got %b expected %b", o.name, bus.gnt, o.gnt); end
    checks++;
    if (bus.enb !== o.enb) begin errors++; $display("FAIL %s enb: got %b expected %b", o.name, bus.enb, o.enb); end
    checks++;
    if (bus.d !== o.d) begin errors++; $display("FAIL %s d: got %h expected %h", o.name, bus.d, o.d); end
    checks++;
    if (bus.q !== o.q) begin errors++; $display("FAIL %s q: got %h expected %h", o.name, bus.q, o.q); end
    checks++;
    if (bus.busy !== o.busy) begin errors++; $display("FAIL %s busy: got %b expected %b", o.name, bus.busy, o.busy); end
    $display("txn %s req=%b gnt=%b enb=%b d=%h q=%h busy=%b", o.name, r, bus.gnt, bus.enb, bus.d, bus.q, bus.busy);
  endtask

  task automatic check_zero(input string nm);
    checks++;
    if (bus.gnt !== '0 || bus.enb !== 1'b0 || bus.busy !== 1'b0 || bus.q !== '0 || bus.d !== '0) begin
      errors++;
      $display("FAIL %s: got gnt=%b enb=%b busy=%b q=%h d=%h expected all zero",
               nm, bus.gnt, bus.enb, bus.busy, bus.q, bus.d);
    end
    $display("txn %s gnt=%b enb=%b q=%h", nm, bus.gnt, bus.enb, bus.q);
  endtask

  task automatic model_reset();
    m_q = '0; m_d = '0; m_enb = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    bus.req = '1;
    for (int i = 0; i < NREQ; i++) set_wd(i, 8'h60 + 8'(i));
    set_lock('0);
    repeat (2) @(posedge cclk);
    #1;
    check_zero("reset_hold");
    rst = 1'b0;
    bus.req = '0;
    model_reset();
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] seq [8];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) set_wd(i, 8'(i * 16 + c));
      step(4'b1111, seq[c], 1'b0, $sformatf("fair%0d", c));
    end
  endtask

  task automatic test_single();
    set_wd(2, 8'hA5);
    step(4'b0100, 4'b0100, 1'b0, "single_gnt");
    step(4'b0000, 4'b0000, 1'b0, "single_store");
    checks++;
    if (bus.q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected a5", bus.q); end
  endtask

  task automatic test_pointer();
    set_wd(0, 8'h11); set_wd(1, 8'h22);
    step(4'b0010, 4'b0010, 1'b0, "ptr_gnt1");
    step(4'b0011, 4'b0001, 1'b0, "ptr_gnt0");
    step(4'b0011, 4'b0010, 1'b0, "ptr_gnt1_again");
  endtask

  task automatic test_idle_hold();
    set_wd(3, 8'h3C);
    step(4'b1000, 4'b1000, 1'b0, "idle_write");
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 1'b0, $sformatf("idle%0d", c));
    checks++;
    if (bus.q !== 8'h3C) begin errors++; $display("FAIL idle_q: got %h expected 3c", bus.q); end
  endtask

  task automatic test_midop_reset();
    bus.req = 4'b1111;
    #3;
    rst = 1'b1;
    #1;
    check_zero("midreset_immediate");
    @(posedge cclk);
    #1;
    check_zero("midreset_held");
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NREQ; i++) set_wd(i, 8'hC0 + 8'(i));
    step(4'b1111, 4'b0001, 1'b0, "b2b_ptr0");
    step(4'b1000, 4'b1000, 1'b0, "b2b_wrap");
    step(4'b0001, 4'b0001, 1'b0, "b2b_after_wrap");
    step(4'b0001, 4'b0001, 1'b0, "b2b_sole");
    step(4'b0000, 4'b0000, 1'b0, "b2b_drain");
  endtask

`ifdef FF_ARB_LOCK_EN
  task automatic test_lock();
    @(posedge cclk); #1;
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    set_wd(0, 8'h50); set_wd(1, 8'h77);
    set_lock(4'b0001);
    step(4'b0011, 4'b0001, 1'b0, "lock_first");
    for (int c = 0; c < 4; c++) begin
      set_wd(0, 8'h51 + 8'(c));
      step(4'b0011, 4'b0001, 1'b1, $sformatf("lock_hold%0d", c));
    end
    set_lock(4'b0000);
    step(4'b0011, 4'b0010, 1'b0, "lock_release");
    step(4'b0000, 4'b0000, 1'b0, "lock_drain");
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req   = '0;
    bus.wdata = '0;
    test_reset();
    test_fairness();
    test_single();
    test_pointer();
    test_idle_hold();
    test_midop_reset();
    test_back_to_back();
`ifdef FF_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
